// File: rtl/usc_rv_dec_queue_if.sv
// Fetch-to-decode bundle interface for the decode queue.
// slave is the queue's own view; master is the fetch/decode environment.
interface usc_rv_dec_queue_if #(
  parameter int LANES  = 2,
  parameter int INFO_W = 4
);
  logic                    in_vld_i;
  logic [LANES-1:0]        in_mask_i;
  logic [LANES*32-1:0]     in_data_i;
  logic [31:0]             in_pc_i;
  logic [INFO_W-1:0]       in_info_i;
  logic [1:0]              in_fault_i;
  logic                    in_rdy_o;
  logic [LANES-1:0]        out_vld_o;
  logic [LANES*32-1:0]     out_data_o;
  logic [LANES*32-1:0]     out_pc_o;
  logic [LANES*INFO_W-1:0] out_info_o;
  logic [LANES*2-1:0]      out_fault_o;
  logic [LANES-1:0]        out_rdy_i;

  modport slave (
    input  in_vld_i, in_mask_i, in_data_i, in_pc_i, in_info_i, in_fault_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_data_o, out_pc_o, out_info_o, out_fault_o
  );

  modport master (
    output in_vld_i, in_mask_i, in_data_i, in_pc_i, in_info_i, in_fault_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_data_o, out_pc_o, out_info_o, out_fault_o
  );
endinterface

// File: rtl/usc_rv_dec_queue.sv
// Decode-stage instruction queue: packs sparse fetch bundles into a circular
// buffer and presents the oldest LANES entries to the decoders.
module usc_rv_dec_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int INFO_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  usc_rv_dec_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [31:0]       data_q  [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic [INFO_W-1:0] info_q  [DEPTH];
  logic [1:0]        fault_q [DEPTH];

  logic              in_rdy;
  logic              push_en;
  logic [CW-1:0]     npush;
  logic [CW-1:0]     npop;
  logic              pop_run;
  logic [LANES-1:0]  wr_en;
  logic [PW-1:0]     wr_idx [LANES];
  logic [PW-1:0]     rd_idx [LANES];
  logic [LANES-1:0]  out_vld;

  // Ready looks only at registered occupancy so it never waits on same-cycle pops.
  assign in_rdy  = (CW'(DEPTH) - count_q) >= CW'(LANES);
  assign push_en = bus.in_vld_i && in_rdy && !flush_i;

  always_comb begin
    npush = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_en[k]  = 1'b0;
      wr_idx[k] = wr_ptr_q + npush[PW-1:0];
      if (push_en && bus.in_mask_i[k]) begin
        wr_en[k] = 1'b1;
        npush    = npush + CW'(1);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      out_vld[j] = count_q > CW'(j);
      rd_idx[j]  = rd_ptr_q + PW'(j);
    end
  end

  // Only the unbroken run of ready lanes from lane 0 pops, keeping pops in order.
  always_comb begin
    npop    = '0;
    pop_run = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if (pop_run && out_vld[j] && bus.out_rdy_i[j]) begin
        npop = npop + CW'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + npop[PW-1:0];
    wr_ptr_d = wr_ptr_q + npush[PW-1:0];
    count_d  = count_q + npush - npop;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; a faulted bundle stores zero instructions.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) begin
        data_q[wr_idx[k]]  <= (|bus.in_fault_i) ? 32'b0 : bus.in_data_i[32*k +: 32];
        pc_q[wr_idx[k]]    <= bus.in_pc_i + (32'(k) << 2);
        info_q[wr_idx[k]]  <= bus.in_info_i;
        fault_q[wr_idx[k]] <= bus.in_fault_i;
      end
    end
  end

  always_comb begin
    bus.out_data_o  = '0;
    bus.out_pc_o    = '0;
    bus.out_info_o  = '0;
    bus.out_fault_o = '0;
    for (int j = 0; j < LANES; j++) begin
      bus.out_data_o[32*j +: 32]         = data_q[rd_idx[j]];
      bus.out_pc_o[32*j +: 32]           = pc_q[rd_idx[j]];
      bus.out_info_o[INFO_W*j +: INFO_W] = info_q[rd_idx[j]];
      bus.out_fault_o[2*j +: 2]          = fault_q[rd_idx[j]];
    end
  end

  assign bus.in_rdy_o  = in_rdy;
  assign bus.out_vld_o = out_vld;
  assign count_o       = count_q;

  count_le_depth: assert property (@(posedge clk_i) disable iff (!rstn_i) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_usc_rv_dec_queue.sv
// Directed bench for usc_rv_dec_queue (LANES=2, DEPTH=8, INFO_W=4) with a
// reference queue for the random wrap-around section.
module tb_usc_rv_dec_queue;
  logic       clk_i;
  logic       rstn_i;
  logic       flush_i;
  logic [3:0] count_o;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] qPc   [$];
  logic [31:0] qData [$];

  usc_rv_dec_queue_if #(.LANES(2), .INFO_W(4)) bus ();

  usc_rv_dec_queue #(.LANES(2), .DEPTH(8), .INFO_W(4)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic vld, input logic [1:0] mask, input logic [63:0] data,
                               input logic [31:0] pc, input logic [3:0] info, input logic [1:0] fault,
                               input logic [1:0] rdy, input logic fl);
    bus.in_vld_i   = vld;
    bus.in_mask_i  = mask;
    bus.in_data_i  = data;
    bus.in_pc_i    = pc;
    bus.in_info_i  = info;
    bus.in_fault_i = fault;
    bus.out_rdy_i  = rdy;
    flush_i        = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic       vld;
    logic [1:0] mask;
    logic [1:0] rdy;
    logic       expRdy;
    int         sz;
    logic [31:0] pc;

    idle();
    rstn_i = 1'b0;
    #12;
    checkOutput("reset_count", 64'(count_o), 64'd0);
    checkOutput("reset_vld", 64'(bus.out_vld_o), 64'd0);
    checkOutput("reset_rdy", 64'(bus.in_rdy_o), 64'd1);
    rstn_i = 1'b1;
    tick();

    // Fill to capacity with no pops; ready holds while two slots remain free.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b11, {32'h2000_0000 + 32'(2*i+1), 32'h2000_0000 + 32'(2*i)},
                    32'h100 + 32'(8*i), 4'h3, 2'b00, 2'b00, 1'b0);
      tick();
      idle();
      checkOutput("fill_count", 64'(count_o), 64'(2*(i+1)));
      checkOutput("fill_rdy", 64'(bus.in_rdy_o), (i < 3) ? 64'd1 : 64'd0);
    end
    applyStimulus(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 32'h900, 4'h0, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("full_nopush_count", 64'(count_o), 64'd8);
    checkOutput("full_nopush_pc0", 64'(bus.out_pc_o[31:0]), 64'h100);

    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_vld", 64'(bus.out_vld_o), 64'd3);
      checkOutput("drain_pc0", 64'(bus.out_pc_o[31:0]), 64'(32'h100 + 32'(8*i)));
      checkOutput("drain_pc1", 64'(bus.out_pc_o[63:32]), 64'(32'h104 + 32'(8*i)));
      checkOutput("drain_data0", 64'(bus.out_data_o[31:0]), 64'(32'h2000_0000 + 32'(2*i)));
      tick();
      checkOutput("drain_count", 64'(count_o), 64'(6 - 2*i));
    end
    idle();
    checkOutput("drain_vld_empty", 64'(bus.out_vld_o), 64'd0);

    // Sparse mask: only slot 1 is pushed and lands in lane 0.
    applyStimulus(1'b1, 2'b10, {32'hAAAA_0013, 32'hDEAD_BEEF}, 32'h200, 4'h1, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("sparse_vld", 64'(bus.out_vld_o), 64'd1);
    checkOutput("sparse_pc", 64'(bus.out_pc_o[31:0]), 64'h204);
    checkOutput("sparse_data", 64'(bus.out_data_o[31:0]), 64'hAAAA_0013);
    checkOutput("sparse_count", 64'(count_o), 64'd1);

    applyStimulus(1'b1, 2'b11, {32'h0000_0033, 32'h0000_0030}, 32'h300, 4'h5, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("partial_count3", 64'(count_o), 64'd3);
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b01, 1'b0);
    tick();
    idle();
    checkOutput("partial_pop1_count", 64'(count_o), 64'd2);
    checkOutput("partial_pop1_pc0", 64'(bus.out_pc_o[31:0]), 64'h300);
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b10, 1'b0);
    tick();
    idle();
    checkOutput("gap_nopop_count", 64'(count_o), 64'd2);
    checkOutput("gap_nopop_pc0", 64'(bus.out_pc_o[31:0]), 64'h300);
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b11, 1'b0);
    tick();
    idle();
    checkOutput("partial_drain_count", 64'(count_o), 64'd0);

    // Faulted bundle keeps pc/info/fault but zeroes the instruction words.
    applyStimulus(1'b1, 2'b11, {32'h9ABC_DEF0, 32'h1234_5678}, 32'h400, 4'hA, 2'b10, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("fault_data", bus.out_data_o, 64'h0);
    checkOutput("fault_bits", 64'(bus.out_fault_o), 64'hA);
    checkOutput("fault_pc", bus.out_pc_o, {32'h404, 32'h400});
    checkOutput("fault_info", 64'(bus.out_info_o), 64'hAA);
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b11, 1'b0);
    tick();
    idle();
    checkOutput("fault_drain_count", 64'(count_o), 64'd0);

    // Flush collides with a push and a pop.
    applyStimulus(1'b1, 2'b11, 64'h1, 32'h500, 4'h0, 2'b00, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 64'h2, 32'h508, 4'h0, 2'b00, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b01, 64'h3, 32'h510, 4'h0, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("preflush_count", 64'(count_o), 64'd5);
    applyStimulus(1'b1, 2'b11, 64'h4, 32'h518, 4'h0, 2'b00, 2'b11, 1'b1);
    tick();
    idle();
    checkOutput("flush_count", 64'(count_o), 64'd0);
    checkOutput("flush_vld", 64'(bus.out_vld_o), 64'd0);
    checkOutput("flush_rdy", 64'(bus.in_rdy_o), 64'd1);

    // Random push/pop against a reference queue, crossing the pointer wrap.
    for (int c = 0; c < 20; c++) begin
      vld    = ($urandom_range(0, 3) != 0);
      mask   = 2'($urandom_range(0, 3));
      rdy    = 2'($urandom_range(0, 3));
      sz     = qPc.size();
      expRdy = (8 - sz) >= 2;
      pc     = 32'h1000 + 32'(16*c);
      checkOutput("rand_count", 64'(count_o), 64'(sz));
      checkOutput("rand_rdy", 64'(bus.in_rdy_o), 64'(expRdy));
      checkOutput("rand_vld", 64'(bus.out_vld_o), {62'd0, sz > 1, sz > 0});
      if (sz > 0) begin
        checkOutput("rand_pc0", 64'(bus.out_pc_o[31:0]), 64'(qPc[0]));
        checkOutput("rand_data0", 64'(bus.out_data_o[31:0]), 64'(qData[0]));
      end
      if (sz > 1) begin
        checkOutput("rand_pc1", 64'(bus.out_pc_o[63:32]), 64'(qPc[1]));
      end
      applyStimulus(vld, mask, {pc ^ 32'h5A5A_0004, pc ^ 32'h5A5A_0000}, pc, 4'h7, 2'b00, rdy, 1'b0);
      tick();
      if (sz > 0 && rdy[0]) begin
        void'(qPc.pop_front());
        void'(qData.pop_front());
        if (sz > 1 && rdy[1]) begin
          void'(qPc.pop_front());
          void'(qData.pop_front());
        end
      end
      if (vld && expRdy) begin
        for (int k = 0; k < 2; k++) begin
          if (mask[k]) begin
            qPc.push_back(pc + 32'(4*k));
            qData.push_back(pc ^ (32'h5A5A_0000 + 32'(4*k)));
          end
        end
      end
    end
    idle();
    checkOutput("rand_final_count", 64'(count_o), 64'(qPc.size()));

    // Asynchronous reset between edges clears a non-empty queue at once.
    applyStimulus(1'b0, 2'b00, 64'h0, 32'h0, 4'h0, 2'b00, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b11, 64'h55, 32'h600, 4'h0, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    checkOutput("prereset_count", 64'(count_o), 64'd2);
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("async_reset_count", 64'(count_o), 64'd0);
    checkOutput("async_reset_vld", 64'(bus.out_vld_o), 64'd0);
    checkOutput("async_reset_rdy", 64'(bus.in_rdy_o), 64'd1);
    #2;
    rstn_i = 1'b1;
    tick();
    checkOutput("post_reset_count", 64'(count_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
